// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: writeback has priority, while long-latency results
// queue in an in-order FIFO and drain into idle cycles or preempt writeback after a bounded wait.
module rf_write_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wb_we,
   input  logic [4:0]                wb_waddr,
   input  logic [63:0]               wb_wdata,
   output logic                      wb_hold,
   input  logic                      lu_valid,
   output logic                      lu_ready,
   input  logic [4:0]                lu_waddr,
   input  logic [63:0]               lu_wdata,
   output logic                      rf_we,
   output logic [4:0]                rf_waddr,
   output logic [63:0]               rf_wdata,
   output logic [$clog2(DEPTH):0]    fifo_count,
   output logic [31:0]               pend_mask
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SC_W  = $clog2(STARVE_MAX + 1);

   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic [SC_W-1:0]  starve_cnt;
   logic [DEPTH-1:0] occ;

   logic [4:0]  waddr_mem [DEPTH];
   logic [63:0] wdata_mem [DEPTH];

   logic wb_req;
   logic fifo_empty;
   logic starved;
   logic grant_lu;
   logic push;
   logic pop;

   function automatic logic [SC_W-1:0] starve_inc(input logic [SC_W-1:0] cnt);
      return (cnt >= SC_W'(STARVE_MAX)) ? cnt : cnt + SC_W'(1);
   endfunction

   assign wb_req     = wb_we && (wb_waddr != 5'd0);
   assign fifo_empty = (count == '0);
   assign lu_ready   = (count != CNT_W'(DEPTH));
   assign starved    = (starve_cnt >= SC_W'(STARVE_MAX));
   assign grant_lu   = !fifo_empty && (!wb_req || starved);
   // x0 results complete the handshake but never occupy an entry
   assign push       = lu_valid && lu_ready && (lu_waddr != 5'd0);
   assign pop        = grant_lu;

   assign fifo_count = count;

   always_comb begin
      rf_we    = wb_req;
      rf_waddr = wb_waddr;
      rf_wdata = wb_wdata;
      wb_hold  = 1'b0;
      if (grant_lu) begin
         rf_we    = 1'b1;
         rf_waddr = waddr_mem[head];
         rf_wdata = wdata_mem[head];
         wb_hold  = wb_req;
      end
   end

   // Per-entry occupancy lets the hazard mask be a flat OR without pointer arithmetic
   always_comb begin
      pend_mask = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (occ[i]) begin
            pend_mask[waddr_mem[i]] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head       <= '0;
         tail       <= '0;
         count      <= '0;
         starve_cnt <= '0;
         occ        <= '0;
      end else begin
         if (push) begin
            tail      <= tail + PTR_W'(1);
            occ[tail] <= 1'b1;
         end
         if (pop) begin
            head      <= head + PTR_W'(1);
            occ[head] <= 1'b0;
         end
         count <= count + CNT_W'(push) - CNT_W'(pop);
         if (fifo_empty || pop) begin
            starve_cnt <= '0;
         end else begin
            starve_cnt <= starve_inc(starve_cnt);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         waddr_mem[tail] <= lu_waddr;
         wdata_mem[tail] <= lu_wdata;
      end
   end

endmodule
